sobel_window_gen: RTL and testbench

Streaming 3x3 neighbourhood generator that feeds the Sobel edge stage. It accepts a raster-order pixel stream, one pixel per valid cycle, and buffers the two previous image rows in on-chip line buffers. For every input pixel that completes a full 3x3 neighbourhood, it presents the nine pixels P00..P22 in registers with a one-cycle valid strobe. The Sobel filter connects combinationally to these outputs.

---
 rtl/sobel_pkg.sv | 23 ++
 rtl/sobel_line_buffer.sv | 40 ++++
 rtl/sobel_window_gen.sv | 145 ++++++++++++++
 tb/tb_sobel_window_gen.sv | 373 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sobel_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sobel_pkg
// Purpose  : Shared constants and types for the Sobel 3x3 window generator.
//            Holds the default pixel width, the pix_t type, the default
//            frame geometry and a helper that sizes position counters.
// Revision : 1.0  initial release
// ============================================================================
package sobel_pkg;

  localparam int SOBEL_PIX_W      = 8;
  localparam int SOBEL_IMG_WIDTH  = 640;
  localparam int SOBEL_IMG_HEIGHT = 480;

  typedef logic [SOBEL_PIX_W-1:0] pix_t;

  // Counter width able to hold 0..n-1; never narrower than one bit.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sobel_line_buffer.sv
`default_nettype none
// ============================================================================
// Module   : sobel_line_buffer
// Purpose  : One image row of pixel storage, DEPTH x DATA_W, single clock.
//            The read port is asynchronous, so a read and a write to the same
//            address in one cycle return the old contents (read-before-write).
//            Storage is deliberately not reset.
// Ports    : clk      - clock
//            wr_en    - write strobe (one pixel accepted)
//            addr     - shared read/write address (column)
//            wr_data  - data written at the rising edge
//            rd_data  - current contents at addr
// Revision : 1.0  initial release
// ============================================================================
module sobel_line_buffer
  import sobel_pkg::*;
#(
  parameter int DEPTH  = SOBEL_IMG_WIDTH,
  parameter int DATA_W = SOBEL_PIX_W,
  parameter int ADDR_W = cnt_w(DEPTH)
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [DEPTH];

  assign rd_data = mem[addr];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[addr] <= wr_data;
    end
  end

endmodule
`default_nettype wire

// File: rtl/sobel_window_gen.sv
`default_nettype none
// ============================================================================
// Module   : sobel_window_gen
// Purpose  : Streaming 3x3 neighbourhood generator for a Sobel edge stage.
//            Buffers the two previous rows and presents the nine pixels of
//            every complete window in registers with a one-cycle strobe.
// Config   : SOBEL_WIN_SOF_EN - when defined, adds the sof input which forces
//            the accepted pixel to position (0,0).
// Ports    : clk         - clock, rising edge
//            rst_n       - asynchronous active-low reset
//            pix_in      - raster-order input pixel
//            pix_valid   - pix_in accepted on this edge (no backpressure)
//            sof         - start of frame (SOBEL_WIN_SOF_EN only)
//            P00..P22    - window; Pij = pixel (r-2+i, c-2+j) of newest pixel
//            win_valid   - one-cycle strobe, new complete window on P00..P22
//            frame_done  - one-cycle strobe with the last window of a frame
// Revision : 1.0  initial release
// ============================================================================
module sobel_window_gen
  import sobel_pkg::*;
#(
  parameter int IMG_WIDTH  = SOBEL_IMG_WIDTH,
  parameter int IMG_HEIGHT = SOBEL_IMG_HEIGHT,
  parameter int PIX_W      = SOBEL_PIX_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [PIX_W-1:0] pix_in,
  input  logic             pix_valid,
`ifdef SOBEL_WIN_SOF_EN
  input  logic             sof,
`endif
  output logic [PIX_W-1:0] P00,
  output logic [PIX_W-1:0] P01,
  output logic [PIX_W-1:0] P02,
  output logic [PIX_W-1:0] P10,
  output logic [PIX_W-1:0] P11,
  output logic [PIX_W-1:0] P12,
  output logic [PIX_W-1:0] P20,
  output logic [PIX_W-1:0] P21,
  output logic [PIX_W-1:0] P22,
  output logic             win_valid,
  output logic             frame_done
);

  localparam int COL_W = cnt_w(IMG_WIDTH);
  localparam int ROW_W = cnt_w(IMG_HEIGHT);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_WIDTH - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_HEIGHT - 1);
  localparam logic [COL_W-1:0] COL_TWO  = COL_W'(2);
  localparam logic [ROW_W-1:0] ROW_TWO  = ROW_W'(2);

  logic [COL_W-1:0] col;
  logic [ROW_W-1:0] row;
  logic [COL_W-1:0] cur_col;
  logic [ROW_W-1:0] cur_row;
  logic             sof_hit;
  logic             accept;
  logic [PIX_W-1:0] lb_r1_rd;
  logic [PIX_W-1:0] lb_r2_rd;

  // Index [0] is the newest column, [2] the oldest (column c-2).
  logic [2:0][PIX_W-1:0] sr0;
  logic [2:0][PIX_W-1:0] sr1;
  logic [2:0][PIX_W-1:0] sr2;

`ifdef SOBEL_WIN_SOF_EN
  assign sof_hit = sof;
`else
  assign sof_hit = 1'b0;
`endif

  assign accept = pix_valid;

  // A sof pixel is treated as (0,0) for addressing, gating and advancing.
  assign cur_col = sof_hit ? '0 : col;
  assign cur_row = sof_hit ? '0 : row;

  // lb_r1 holds row r-1; its old contents cascade into lb_r2 (row r-2).
  sobel_line_buffer #(
    .DEPTH  (IMG_WIDTH),
    .DATA_W (PIX_W),
    .ADDR_W (COL_W)
  ) u_lb_r1 (
    .clk     (clk),
    .wr_en   (accept),
    .addr    (cur_col),
    .wr_data (pix_in),
    .rd_data (lb_r1_rd)
  );

  sobel_line_buffer #(
    .DEPTH  (IMG_WIDTH),
    .DATA_W (PIX_W),
    .ADDR_W (COL_W)
  ) u_lb_r2 (
    .clk     (clk),
    .wr_en   (accept),
    .addr    (cur_col),
    .wr_data (lb_r1_rd),
    .rd_data (lb_r2_rd)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col        <= '0;
      row        <= '0;
      sr0        <= '0;
      sr1        <= '0;
      sr2        <= '0;
      win_valid  <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      // Strobes are cleared on every non-accept edge.
      win_valid  <= accept && (cur_row >= ROW_TWO) && (cur_col >= COL_TWO);
      frame_done <= accept && (cur_row == ROW_LAST) && (cur_col == COL_LAST);
      if (accept) begin
        sr0 <= {sr0[1:0], lb_r2_rd};
        sr1 <= {sr1[1:0], lb_r1_rd};
        sr2 <= {sr2[1:0], pix_in};
        if (cur_col == COL_LAST) begin
          col <= '0;
          row <= (cur_row == ROW_LAST) ? '0 : cur_row + ROW_W'(1);
        end else begin
          col <= cur_col + COL_W'(1);
          row <= cur_row;
        end
      end
    end
  end

  // The shift registers are the output registers; the window is visible
  // for the whole cycle following the accepting edge.
  assign P00 = sr0[2];
  assign P01 = sr0[1];
  assign P02 = sr0[0];
  assign P10 = sr1[2];
  assign P11 = sr1[1];
  assign P12 = sr1[0];
  assign P20 = sr2[2];
  assign P21 = sr2[1];
  assign P22 = sr2[0];

endmodule
`default_nettype wire

// File: tb/tb_sobel_window_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_sobel_window_gen
// Purpose  : Self-checking bench for sobel_window_gen on a 5x4 frame. A
//            reference model stores each accepted pixel in an image array at
//            its raster position and builds the expected window directly
//            from that image.
// Config   : SOBEL_WIN_SOF_EN - enables the sof scenario.
// Revision : 1.0  initial release
// ============================================================================
module tb_sobel_window_gen;
  import sobel_pkg::*;

  localparam int W = 5;
  localparam int H = 4;
`ifdef SOBEL_WIN_SOF_EN
  localparam bit SOF_EN = 1'b1;
`else
  localparam bit SOF_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] pix_in;
  logic       pix_valid;
  logic       sof_drv;
  logic [7:0] P00, P01, P02, P10, P11, P12, P20, P21, P22;
  logic       win_valid, frame_done;
  logic [71:0] win_obs;

  assign win_obs = {P00, P01, P02, P10, P11, P12, P20, P21, P22};

  always #5 clk = ~clk;

  sobel_window_gen #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .PIX_W(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .pix_in     (pix_in),
    .pix_valid  (pix_valid),
`ifdef SOBEL_WIN_SOF_EN
    .sof        (sof_drv),
`endif
    .P00        (P00), .P01 (P01), .P02 (P02),
    .P10        (P10), .P11 (P11), .P12 (P12),
    .P20        (P20), .P21 (P21), .P22 (P22),
    .win_valid  (win_valid),
    .frame_done (frame_done)
  );

  int checks = 0;
  int errors = 0;

  // Reference model state
  pix_t        img [H][W];
  int          mrow, mcol;
  logic        exp_wv, exp_fd;
  logic [71:0] exp_win;
  logic        hold_known;
  logic [71:0] hold_val;

  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

  function automatic int edge_mag(input logic [71:0] w);
    int p [3][3];
    int gx, gy;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++)
        p[i][j] = int'(w[(8 - (3*i + j))*8 +: 8]);
    gx = (p[0][2] + 2*p[1][2] + p[2][2]) - (p[0][0] + 2*p[1][0] + p[2][0]);
    gy = (p[2][0] + 2*p[2][1] + p[2][2]) - (p[0][0] + 2*p[0][1] + p[0][2]);
    return iabs(gx) + iabs(gy);
  endfunction

  task automatic model_reset();
    mrow = 0; mcol = 0;
    exp_wv = 1'b0; exp_fd = 1'b0;
    hold_known = 1'b1; hold_val = '0;
  endtask

  // Drive one cycle (called at a falling edge), update the model at the
  // rising edge, return at the next falling edge for sampling.
  task automatic cycle(input logic v, input logic [7:0] p, input logic s);
    pix_valid = v; pix_in = p; sof_drv = s;
    @(posedge clk);
    if (v) begin
      if (s && SOF_EN) begin mrow = 0; mcol = 0; end
      img[mrow][mcol] = p;
      exp_wv = (mrow >= 2) && (mcol >= 2);
      exp_fd = (mrow == H-1) && (mcol == W-1);
      if (exp_wv)
        for (int i = 0; i < 3; i++)
          for (int j = 0; j < 3; j++)
            exp_win[(8 - (3*i + j))*8 +: 8] = img[mrow-2+i][mcol-2+j];
      hold_known = exp_wv;
      hold_val   = exp_win;
      if (mcol == W-1) begin
        mcol = 0;
        mrow = (mrow == H-1) ? 0 : mrow + 1;
      end else begin
        mcol = mcol + 1;
      end
    end else begin
      exp_wv = 1'b0; exp_fd = 1'b0;
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    pix_valid = 1'b0; pix_in = '0; sof_drv = 1'b0; rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (win_obs !== 72'd0 || win_valid !== 1'b0 || frame_done !== 1'b0) begin
      errors++;
      $display("FAIL reset_state win=%h wv=%b fd=%b expected all zero", win_obs, win_valid, frame_done);
    end
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_continuous();
    int nwin = 0;
    logic [71:0] first_exp;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++)
        first_exp[(8 - (3*i + j))*8 +: 8] = 8'(10*i + j);
    for (int k = 0; k < W*H; k++) begin
      cycle(1'b1, 8'(10*(k/W) + k%W), 1'b0);
      checks++;
      if (win_valid !== exp_wv || frame_done !== exp_fd) begin
        errors++;
        $display("FAIL cont_strobe k=%0d wv=%b fd=%b expected %b %b", k, win_valid, frame_done, exp_wv, exp_fd);
      end
      if (exp_wv) begin
        checks++;
        if (win_obs !== exp_win) begin
          errors++;
          $display("FAIL cont_window k=%0d got %h expected %h", k, win_obs, exp_win);
        end
      end
      if (win_valid === 1'b1) begin
        nwin++;
        if (nwin == 1) begin
          checks++;
          if (k != 12 || win_obs !== first_exp) begin
            errors++;
            $display("FAIL cont_first k=%0d got %h expected k=12 %h", k, win_obs, first_exp);
          end
        end
      end
    end
    checks++;
    if (nwin != 6 || win_obs[7:0] !== 8'd34 || frame_done !== 1'b1) begin
      errors++;
      $display("FAIL cont_count windows=%0d P22=%0d fd=%b expected 6 34 1", nwin, win_obs[7:0], frame_done);
    end
  endtask

  task automatic test_alternate();
    int nwin = 0;
    int k = 0;
    while (k < W*H) begin
      cycle(1'b0, 8'hEE, 1'b0);
      checks++;
      if (win_valid !== 1'b0 || frame_done !== 1'b0 || (hold_known && win_obs !== hold_val)) begin
        errors++;
        $display("FAIL alt_idle k=%0d wv=%b fd=%b win=%h expected 0 0 hold %b %h", k, win_valid, frame_done, win_obs, hold_known, hold_val);
      end
      cycle(1'b1, 8'(10*(k/W) + k%W), 1'b0);
      checks++;
      if (win_valid !== exp_wv || frame_done !== exp_fd || (exp_wv && win_obs !== exp_win)) begin
        errors++;
        $display("FAIL alt_accept k=%0d wv=%b fd=%b win=%h expected %b %b %h", k, win_valid, frame_done, win_obs, exp_wv, exp_fd, exp_win);
      end
      if (win_valid === 1'b1) nwin++;
      k++;
    end
    checks++;
    if (nwin != 6) begin
      errors++;
      $display("FAIL alt_count windows=%0d expected 6", nwin);
    end
  endtask

  task automatic test_back_to_back();
    int nwin = 0, nfd = 0;
    for (int k = 0; k < 2*W*H; k++) begin
      int r = (k % (W*H)) / W;
      int c = k % W;
      cycle(1'b1, 8'((k >= W*H ? 100 : 0) + 10*r + c), 1'b0);
      checks++;
      if (win_valid !== exp_wv || frame_done !== exp_fd || (exp_wv && win_obs !== exp_win)) begin
        errors++;
        $display("FAIL b2b_cycle k=%0d wv=%b fd=%b win=%h expected %b %b %h", k, win_valid, frame_done, win_obs, exp_wv, exp_fd, exp_win);
      end
      if (win_valid === 1'b1) begin
        nwin++;
        if (nwin == 7) begin
          checks++;
          if (win_obs[71:64] !== 8'd100 || win_obs[7:0] !== 8'd122) begin
            errors++;
            $display("FAIL b2b_frame2_first P00=%0d P22=%0d expected 100 122", win_obs[71:64], win_obs[7:0]);
          end
        end
      end
      if (frame_done === 1'b1) nfd++;
    end
    checks++;
    if (nwin != 12 || nfd != 2) begin
      errors++;
      $display("FAIL b2b_count windows=%0d frame_done=%0d expected 12 2", nwin, nfd);
    end
  endtask

  task automatic test_reset_midframe();
    int nwin = 0, nfd = 0;
    for (int k = 0; k < 7; k++) cycle(1'b1, 8'(200 + k), 1'b0);
    pix_valid = 1'b1; pix_in = 8'h77;
    rst_n = 1'b0;
    #1;
    checks++;
    if (win_obs !== 72'd0 || win_valid !== 1'b0 || frame_done !== 1'b0) begin
      errors++;
      $display("FAIL midreset_assert win=%h wv=%b fd=%b expected all zero", win_obs, win_valid, frame_done);
    end
    repeat (2) @(negedge clk);
    checks++;
    if (win_obs !== 72'd0 || win_valid !== 1'b0 || frame_done !== 1'b0) begin
      errors++;
      $display("FAIL midreset_hold win=%h wv=%b fd=%b expected all zero", win_obs, win_valid, frame_done);
    end
    rst_n = 1'b1;
    model_reset();
    for (int k = 0; k < W*H; k++) begin
      cycle(1'b1, 8'(10*(k/W) + k%W), 1'b0);
      checks++;
      if (win_valid !== exp_wv || frame_done !== exp_fd || (exp_wv && win_obs !== exp_win)) begin
        errors++;
        $display("FAIL midreset_frame k=%0d wv=%b fd=%b win=%h expected %b %b %h", k, win_valid, frame_done, win_obs, exp_wv, exp_fd, exp_win);
      end
      if (win_valid === 1'b1) nwin++;
      if (frame_done === 1'b1) nfd++;
    end
    checks++;
    if (nwin != 6 || nfd != 1) begin
      errors++;
      $display("FAIL midreset_count windows=%0d frame_done=%0d expected 6 1", nwin, nfd);
    end
  endtask

`ifdef SOBEL_WIN_SOF_EN
  task automatic test_sof();
    int nwin = 0, nfd = 0, first_k = -1;
    for (int k = 0; k < 7; k++) begin
      cycle(1'b1, 8'(10*(k/W) + k%W), 1'b0);
      if (frame_done === 1'b1) nfd++;
    end
    for (int k = 0; k < W*H; k++) begin
      // An ignored sof on an idle cycle must not disturb alignment.
      if (k == 4) begin
        cycle(1'b0, 8'h00, 1'b1);
        checks++;
        if (win_valid !== 1'b0 || frame_done !== 1'b0) begin
          errors++;
          $display("FAIL sof_idle wv=%b fd=%b expected 0 0", win_valid, frame_done);
        end
      end
      cycle(1'b1, 8'(50 + k), (k == 0));
      checks++;
      if (win_valid !== exp_wv || frame_done !== exp_fd || (exp_wv && win_obs !== exp_win)) begin
        errors++;
        $display("FAIL sof_cycle k=%0d wv=%b fd=%b win=%h expected %b %b %h", k, win_valid, frame_done, win_obs, exp_wv, exp_fd, exp_win);
      end
      if (win_valid === 1'b1) begin
        nwin++;
        if (first_k < 0) first_k = k;
      end
      if (frame_done === 1'b1) nfd++;
    end
    checks++;
    if (first_k != 12 || nwin != 6 || nfd != 1) begin
      errors++;
      $display("FAIL sof_summary first=%0d windows=%0d frame_done=%0d expected 12 6 1", first_k, nwin, nfd);
    end
  endtask
`endif

  task automatic test_uniform();
    int nwin = 0;
    for (int k = 0; k < W*H; k++) begin
      cycle(1'b1, 8'd255, 1'b0);
      checks++;
      if (win_valid !== exp_wv || frame_done !== exp_fd) begin
        errors++;
        $display("FAIL uni_strobe k=%0d wv=%b fd=%b expected %b %b", k, win_valid, frame_done, exp_wv, exp_fd);
      end
      if (exp_wv) begin
        nwin++;
        checks++;
        if (win_obs !== {9{8'hFF}} || edge_mag(win_obs) != 0) begin
          errors++;
          $display("FAIL uni_window k=%0d got %h mag=%0d expected all FF mag 0", k, win_obs, edge_mag(win_obs));
        end
      end
    end
    checks++;
    if (nwin != 6) begin
      errors++;
      $display("FAIL uni_count windows=%0d expected 6", nwin);
    end
  endtask

  task automatic test_random();
    int acc = 0;
    int nwin = 0, nfd = 0;
    while (acc < 3*W*H) begin
      logic v;
      v = ($urandom_range(0, 3) != 0);
      cycle(v, 8'($urandom_range(0, 255)), 1'b0);
      if (v) acc++;
      checks++;
      if (win_valid !== exp_wv || frame_done !== exp_fd) begin
        errors++;
        $display("FAIL rand_strobe acc=%0d wv=%b fd=%b expected %b %b", acc, win_valid, frame_done, exp_wv, exp_fd);
      end
      if (exp_wv) begin
        checks++;
        if (win_obs !== exp_win) begin
          errors++;
          $display("FAIL rand_window acc=%0d got %h expected %h", acc, win_obs, exp_win);
        end
      end else if (hold_known) begin
        checks++;
        if (win_obs !== hold_val) begin
          errors++;
          $display("FAIL rand_hold acc=%0d got %h expected %h", acc, win_obs, hold_val);
        end
      end
      if (win_valid === 1'b1) nwin++;
      if (frame_done === 1'b1) nfd++;
    end
    checks++;
    if (nwin != 18 || nfd != 3) begin
      errors++;
      $display("FAIL rand_count windows=%0d frame_done=%0d expected 18 3", nwin, nfd);
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    @(negedge clk);
    test_reset();
    test_continuous();
    test_alternate();
    test_back_to_back();
    test_reset_midframe();
`ifdef SOBEL_WIN_SOF_EN
    test_sof();
`endif
    test_uniform();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
